// File: rtl/regfile_sb.sv
// Parametrised integer register file with two write ports and a built-in pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NREAD*ADDR_W-1:0] r_number,
    output logic [NREAD*DATA_W-1:0] data_out,
    output logic [NREAD-1:0]        r_busy,
    input  logic                    w0_en,
    input  logic [ADDR_W-1:0]       w0_number,
    input  logic [DATA_W-1:0]       w0_data,
    input  logic                    w1_en,
    input  logic [ADDR_W-1:0]       w1_number,
    input  logic [DATA_W-1:0]       w1_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_number,
    output logic [ADDR_W:0]         busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   busy_count_q;
    logic [ADDR_W:0]   busy_count_d;

    logic w0_act;
    logic w1_act;
    logic rsv_act;

    assign w0_act  = w0_en  && (w0_number  != '0);
    assign w1_act  = w1_en  && (w1_number  != '0);
    assign rsv_act = rsv_en && (rsv_number != '0);

    // Write order encodes priority: w1 overrides w0, reserve overrides the write's pending clear.
    // NOTE: every always_comb output starts from a full default so no path can infer a latch.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (w0_act) begin
            regs_d[w0_number] = w0_data;
            pend_d[w0_number] = 1'b0;
        end
        if (w1_act) begin
            regs_d[w1_number] = w1_data;
            pend_d[w1_number] = 1'b0;
        end
        if (rsv_act) begin
            pend_d[rsv_number] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 1; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + (ADDR_W+1)'(pend_d[i]);
        end
    end

    // NOTE: the whole array is reset, so it lives in flops rather than a RAM macro.
    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            pend_q       <= pend_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign rd_addr = r_number[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data = regs_q[rd_addr];
            rd_busy = pend_q[rd_addr];
            if (rd_addr == '0) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (w1_act && (w1_number == rd_addr)) begin
                rd_data = w1_data;
                rd_busy = rsv_act && (rsv_number == rd_addr);
            end else if (w0_act && (w0_number == rd_addr)) begin
                rd_data = w0_data;
                rd_busy = rsv_act && (rsv_number == rd_addr);
            end
`endif
        end

        assign data_out[k*DATA_W +: DATA_W] = rd_data;
        assign r_busy[k]                    = rd_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then randomized traffic against an array model.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                    clk = 1'b0;
    logic                    clr;
    logic [NREAD*ADDR_W-1:0] r_number;
    logic [NREAD*DATA_W-1:0] data_out;
    logic [NREAD-1:0]        r_busy;
    logic                    w0_en, w1_en, rsv_en;
    logic [ADDR_W-1:0]       w0_number, w1_number, rsv_number;
    logic [DATA_W-1:0]       w0_data, w1_data;
    logic [ADDR_W:0]         busy_count;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mregs [DEPTH];
    bit                mpend [DEPTH];

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) dut (
        .clk        (clk),
        .clr        (clr),
        .r_number   (r_number),
        .data_out   (data_out),
        .r_busy     (r_busy),
        .w0_en      (w0_en),
        .w0_number  (w0_number),
        .w0_data    (w0_data),
        .w1_en      (w1_en),
        .w1_number  (w1_number),
        .w1_data    (w1_data),
        .rsv_en     (rsv_en),
        .rsv_number (rsv_number),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < DEPTH; r++) n += int'(mpend[r]);
        return n;
    endfunction

    // Expected read result from the architectural state plus, with bypass, the in-flight writes.
    task automatic exp_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic b);
        d = mregs[a];
        b = mpend[a];
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if ((w1_en && w1_number == a) || (w0_en && w0_number == a)) begin
            d = (w1_en && w1_number == a) ? w1_data : w0_data;
            b = rsv_en && (rsv_number == a);
        end
`endif
    endtask

    task automatic model_update();
        if (clr) begin
            for (int r = 0; r < DEPTH; r++) begin
                mregs[r] = '0;
                mpend[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                bit hit0 = w0_en  && (int'(w0_number)  == r);
                bit hit1 = w1_en  && (int'(w1_number)  == r);
                bit hitr = rsv_en && (int'(rsv_number) == r);
                if (hit1)      mregs[r] = w1_data;
                else if (hit0) mregs[r] = w0_data;
                if (hitr)              mpend[r] = 1'b1;
                else if (hit0 || hit1) mpend[r] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; w0_en = 1'b0; w1_en = 1'b0; rsv_en = 1'b0;
        w0_number = '0; w1_number = '0; rsv_number = '0;
        w0_data = '0; w1_data = '0;
    endtask

    task automatic read_at(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        r_number = {a1, a0};
    endtask

    task automatic check_reads(input string tag);
        logic [DATA_W-1:0] d;
        logic              b;
        #1;
        for (int k = 0; k < NREAD; k++) begin
            exp_read(r_number[k*ADDR_W +: ADDR_W], d, b);
            check({tag, "_data"}, 64'(data_out[k*DATA_W +: DATA_W]), 64'(d));
            check({tag, "_busy"}, 64'(r_busy[k]), 64'(b));
        end
        check({tag, "_count"}, 64'(busy_count), 64'(model_count()));
    endtask

    initial begin
        for (int r = 0; r < DEPTH; r++) begin
            mregs[r] = '0;
            mpend[r] = 1'b0;
        end
        idle();
        read_at(5'd0, 5'd0);

        // Reset then read
        clr = 1'b1;
        step();
        clr = 1'b0;
        read_at(5'd0, 5'd1);
        check_reads("rst_a");
        read_at(5'd31, 5'd0);
        check_reads("rst_b");
        check("rst_count_const", 64'(busy_count), 64'd0);
        check("rst_data_const", 64'(data_out), 64'd0);

        // Dual-write collision on address 5
        w0_en = 1'b1; w0_number = 5'd5; w0_data = 32'h1111;
        w1_en = 1'b1; w1_number = 5'd5; w1_data = 32'h2222;
        read_at(5'd5, 5'd0);
        check_reads("coll_same");
        step();
        idle();
        check_reads("coll_next");
        check("coll_const", 64'(data_out[DATA_W-1:0]), 64'h2222);

        // Writes to register 0 are discarded
        w0_en = 1'b1; w0_number = 5'd0; w0_data = 32'hFFFF;
        w1_en = 1'b1; w1_number = 5'd0; w1_data = 32'hFFFF;
        step();
        idle();
        read_at(5'd0, 5'd5);
        check_reads("zero_reg");
        check("zero_const", 64'(data_out[DATA_W-1:0]), 64'd0);

        // Reserve 7, then write 7
        rsv_en = 1'b1; rsv_number = 5'd7;
        step();
        idle();
        read_at(5'd0, 5'd7);
        check_reads("rsv7");
        check("rsv7_busy_const", 64'(r_busy[1]), 64'd1);
        check("rsv7_count_const", 64'(busy_count), 64'd1);
        w0_en = 1'b1; w0_number = 5'd7; w0_data = 32'hABCD;
        step();
        idle();
        check_reads("wr7");
        check("wr7_data_const", 64'(data_out[2*DATA_W-1:DATA_W]), 64'hABCD);
        check("wr7_count_const", 64'(busy_count), 64'd0);

        // Reserve and write 9 in the same cycle: pending stays set
        rsv_en = 1'b1; rsv_number = 5'd9;
        w1_en = 1'b1; w1_number = 5'd9; w1_data = 32'h55;
        step();
        idle();
        read_at(5'd9, 5'd7);
        check_reads("clash9");
        check("clash9_busy_const", 64'(r_busy[0]), 64'd1);
        check("clash9_count_const", 64'(busy_count), 64'd1);

        // Bypass behaviour on register 3
        rsv_en = 1'b1; rsv_number = 5'd3;
        step();
        idle();
        step();
        w0_en = 1'b1; w0_number = 5'd3; w0_data = 32'hCAFE;
        read_at(5'd9, 5'd3);
        check_reads("byp_same");
`ifdef REGFILE_BYPASS_EN
        check("byp_same_data_const", 64'(data_out[2*DATA_W-1:DATA_W]), 64'hCAFE);
        check("byp_same_busy_const", 64'(r_busy[1]), 64'd0);
`else
        check("byp_same_data_const", 64'(data_out[2*DATA_W-1:DATA_W]), 64'd0);
        check("byp_same_busy_const", 64'(r_busy[1]), 64'd1);
`endif
        step();
        idle();
        check_reads("byp_next");
        check("byp_next_data_const", 64'(data_out[2*DATA_W-1:DATA_W]), 64'hCAFE);

        // Reset mid-operation drops pending bits
        rsv_en = 1'b1; rsv_number = 5'd4;
        step();
        rsv_number = 5'd6;
        step();
        idle();
        read_at(5'd4, 5'd6);
        check_reads("pre_clr");
        clr = 1'b1;
        w1_en = 1'b1; w1_number = 5'd6; w1_data = 32'h77;
        step();
        idle();
        check_reads("post_clr");
        check("post_clr_count_const", 64'(busy_count), 64'd0);
        check("post_clr_r6_const", 64'(data_out[2*DATA_W-1:DATA_W]), 64'd0);
        w0_en = 1'b1; w0_number = 5'd4; w0_data = 32'h44;
        step();
        idle();
        check_reads("late_wr4");
        check("late_wr4_busy_const", 64'(r_busy[0]), 64'd0);

        // Randomized traffic, addresses biased to a small window to force collisions
        for (int i = 0; i < 400; i++) begin
            clr        = ($urandom_range(0, 49) == 0);
            w0_en      = $urandom_range(0, 1) == 1;
            w1_en      = $urandom_range(0, 1) == 1;
            rsv_en     = $urandom_range(0, 2) != 0;
            w0_number  = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 7));
            w1_number  = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 7));
            rsv_number = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 7));
            w0_data    = $urandom;
            w1_data    = $urandom;
            read_at(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, DEPTH-1)));
            check_reads("rand_same");
            step();
        end
        idle();
        read_at(5'd1, 5'd2);
        check_reads("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
